// File: rtl/is_pkg_uart_controller.sv
// Shared types and helpers for the UART controller: word width, RX FSM state
// encoding and the parity check used by the receiver.
package is_pkg_uart_controller;

  localparam int DATA_W = 8;

  // Receive-path states; the transmit path keeps its own state type.
  typedef enum logic [2:0] {
    IDLE,
    RSTRB,
    RDT,
    RPARB,
    RSTB1,
    RSTB2,
    DONE
  } rx_state_t;

  // 1 when the received parity bit disagrees with the data word.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                           input logic              par_bit,
                                           input logic              odd);
    return par_bit ^ (^data) ^ odd;
  endfunction

endpackage

// File: rtl/is_uart_rx_sampler.sv
// RX line front end: 2-flop synchroniser, falling-edge detector and, with
// IS_UART_RX_MAJ_EN defined, a 2-of-3 majority voter over consecutive ticks.
module is_uart_rx_sampler (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic uart_ce_i,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rxd_raw;

  // Flops reset to the idle level so leaving reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      prev_q <= sync_q[1];
    end
  end

  assign rxd_raw = sync_q[1];
  assign fall_o  = prev_q & ~rxd_raw;

`ifdef IS_UART_RX_MAJ_EN
  // Values seen on the two previous ticks; voted with the current one.
  logic [1:0] hist_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hist_q <= 2'b11;
    end else if (uart_ce_i) begin
      hist_q <= {hist_q[0], rxd_raw};
    end
  end

  assign rxd_s_o = (rxd_raw & hist_q[0]) | (rxd_raw & hist_q[1]) |
                   (hist_q[0] & hist_q[1]);
`else
  logic unused_ce;
  assign unused_ce = uart_ce_i;
  assign rxd_s_o   = rxd_raw;
`endif

endmodule

// File: rtl/is_uart_rx_fsm.sv
// UART receiver FSM: mid-bit sampling of start, data (LSB first), optional
// parity and stop bits. IS_UART_RX_MAJ_EN selects 3-tick majority sampling.
module is_uart_rx_fsm
  import is_pkg_uart_controller::*;
#(
  parameter int OVS_RATE   = 16,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              uart_ce_i,
  input  logic              rxd_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_data_en_o,
  output logic              rx_par_err_o,
  output logic              rx_frm_err_o,
  output logic              rxct_r_o
);

  localparam int OVS_W = $clog2(OVS_RATE);
`ifdef IS_UART_RX_MAJ_EN
  localparam int MAJ_OFS = 1;
`else
  localparam int MAJ_OFS = 0;
`endif
  // Start is validated half a bit after the edge; data sampling then repeats
  // once per full bit, i.e. whenever the counter wraps.
  localparam logic [OVS_W-1:0] START_CNT = OVS_W'(OVS_RATE / 2 - 1 + MAJ_OFS);
  localparam logic [OVS_W-1:0] BIT_CNT   = OVS_W'(OVS_RATE - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  logic rxd_s;
  logic fall;

  is_uart_rx_sampler u_sampler (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .uart_ce_i(uart_ce_i),
    .rxd_i    (rxd_i),
    .rxd_s_o  (rxd_s),
    .fall_o   (fall)
  );

  rx_state_t         state_q, state_d;
  logic [OVS_W-1:0]  ovs_q, ovs_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              frm_q, frm_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              rxct_q, rxct_d;
  logic              start_tick;
  logic              bit_tick;

  assign start_tick = uart_ce_i && (ovs_q == START_CNT);
  assign bit_tick   = uart_ce_i && (ovs_q == BIT_CNT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ovs_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rxct_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ovs_q   <= ovs_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
      data_q  <= data_d;
      en_q    <= en_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      rxct_q  <= rxct_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d = state_q;
    ovs_d   = uart_ce_i ? ovs_q + 1'b1 : ovs_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    frm_d   = frm_q;
    data_d  = data_q;
    en_d    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    rxct_d  = rxct_q;

    unique case (state_q)
      IDLE: begin
        ovs_d  = '0;
        rxct_d = 1'b1;
        if (fall) begin
          bit_d   = '0;
          par_d   = 1'b0;
          frm_d   = 1'b0;
          rxct_d  = 1'b0;
          state_d = RSTRB;
        end
      end
      RSTRB: begin
        if (start_tick) begin
          if (rxd_s) begin
            rxct_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ovs_d   = '0;
            bit_d   = '0;
            state_d = RDT;
          end
        end
      end
      RDT: begin
        if (bit_tick) begin
          shift_d = {rxd_s, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_W - 1)) begin
            state_d = (PARITY_EN != 0) ? RPARB : RSTB1;
          end
        end
      end
      RPARB: begin
        if (bit_tick) begin
          par_d   = parity_mismatch(shift_q, rxd_s, ODD);
          state_d = RSTB1;
        end
      end
      RSTB1: begin
        if (bit_tick) begin
          frm_d   = ~rxd_s;
          state_d = (STOP_BITS == 2) ? RSTB2 : DONE;
        end
      end
      RSTB2: begin
        if (bit_tick) begin
          frm_d   = frm_q | ~rxd_s;
          state_d = DONE;
        end
      end
      DONE: begin
        data_d  = shift_q;
        en_d    = 1'b1;
        perr_d  = par_q;
        ferr_d  = frm_q;
        rxct_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        rxct_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data_o    = data_q;
  assign rx_data_en_o = en_q;
  assign rx_par_err_o = perr_q;
  assign rx_frm_err_o = ferr_q;
  assign rxct_r_o     = rxct_q;

endmodule

// File: tb/tb_is_uart_rx_fsm.sv
// Self-checking bench for is_uart_rx_fsm: directed frames with a scoreboard of
// expected words checked on each receive strobe.
module tb_is_uart_rx_fsm;
  import is_pkg_uart_controller::*;

  localparam int OVS = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } exp_t;

  logic              clk_i     = 1'b0;
  logic              rstn_i    = 1'b0;
  logic              uart_ce_i = 1'b1;
  logic              rxd_i     = 1'b1;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_data_en_o;
  logic              rx_par_err_o;
  logic              rx_frm_err_o;
  logic              rxct_r_o;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ce_half = 1'b0;

  is_uart_rx_fsm #(
    .OVS_RATE  (OVS),
    .STOP_BITS (2),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .uart_ce_i   (uart_ce_i),
    .rxd_i       (rxd_i),
    .rx_data_o   (rx_data_o),
    .rx_data_en_o(rx_data_en_o),
    .rx_par_err_o(rx_par_err_o),
    .rx_frm_err_o(rx_frm_err_o),
    .rxct_r_o    (rxct_r_o)
  );

  always #5 clk_i = ~clk_i;

  // Oversampling enable: every clock, or every second clock when ce_half is set.
  always @(negedge clk_i) uart_ce_i = ce_half ? ~uart_ce_i : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest outstanding frame.
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (rx_data_en_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(rx_data_en_o), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("rx_data", 32'(rx_data_o), 32'(cur.data));
          check("par_err", 32'(rx_par_err_o), 32'(cur.perr));
          check("frm_err", 32'(rx_frm_err_o), 32'(cur.ferr));
        end
      end else if (rx_par_err_o !== 1'b0 || rx_frm_err_o !== 1'b0) begin
        check("flags_off_strobe", {30'd0, rx_par_err_o, rx_frm_err_o}, 32'd0);
      end
    end
  end

  task automatic hold(input logic b, input int n);
    rxd_i = b;
    repeat (n) @(negedge clk_i);
  endtask

  // Drives one frame; glitch inverts the line for one clock at each mid tick.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic s1,
                            input logic s2, input bit glitch);
    logic [11:0] bits;
    exp_t        e;
    int          len;
    bits   = {s2, s1, par_bit, d, 1'b0};
    len    = ce_half ? 2 * OVS : OVS;
    e.data = d;
    e.perr = par_bit ^ (^d);
    e.ferr = ~(s1 & s2);
    exp_q.push_back(e);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) check("busy_in_frame", 32'(rxct_r_o), 32'd0);
      for (int c = 0; c < len; c++) begin
        rxd_i = (glitch && c == 8) ? ~bits[i] : bits[i];
        @(negedge clk_i);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(rx_data_o), 32'd0);
    check({tag, "_en"}, 32'(rx_data_en_o), 32'd0);
    check({tag, "_perr"}, 32'(rx_par_err_o), 32'd0);
    check({tag, "_ferr"}, 32'(rx_frm_err_o), 32'd0);
    check({tag, "_rxct"}, 32'(rxct_r_o), 32'd1);
  endtask

  initial begin
    int wait_cnt;
    rstn_i = 1'b0;
    rxd_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rstn_i = 1'b1;
    hold(1'b1, 20);

    // Clean frame, then a parity error.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);

    // Framing error running into a 40-bit break; nothing restarts until high.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 40 * OVS);
    hold(1'b1, 32);
    check("idle_after_break", 32'(rxct_r_o), 32'd1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);

    // Short low glitch: false start, back to idle, last word retained.
    hold(1'b0, 4);
    check("glitch_busy", 32'(rxct_r_o), 32'd0);
    hold(1'b1, 48);
    check("glitch_idle", 32'(rxct_r_o), 32'd1);
    check("data_hold", 32'(rx_data_o), 32'hAA);

    // Reset after three data bits of 0x7E, then the same frame cleanly.
    hold(1'b0, OVS);
    hold(1'b0, OVS);
    hold(1'b1, OVS);
    hold(1'b1, OVS);
    rstn_i = 1'b0;
    rxd_i  = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("mid_reset");
    rstn_i = 1'b1;
    hold(1'b1, 32);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);

    // Enable at half rate: counters must freeze on idle clocks.
    ce_half = 1'b1;
    hold(1'b1, 4);
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 64);
    ce_half = 1'b0;
    hold(1'b1, 8);

`ifdef IS_UART_RX_MAJ_EN
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 32);
`endif

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 400) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
